// File: rtl/bcd_to_seven_seg.sv
// bcd_to_seven_seg: registered BCD-to-seven-segment decoder for one display digit.
// Adds lamp test, blanking, 7447-style ripple leading-zero blanking and an invalid-code flag.
// Every output is registered, so there is exactly one clk cycle of latency.
//
// Parameters:
//   ACTIVE_LOW - 1: a segment is lit when its SEG bit is 0 (common anode).
//                0: a segment is lit when its SEG bit is 1.
//
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   BCD       - digit code; 0-9 are valid, 10-15 are invalid
//   lamp_test - 1 lights all segments (highest priority)
//   blank     - 1 turns all segments off
//   rbi       - ripple-blank in; 1 blanks this digit when it is zero
//   SEG       - segment drive, bit0=a ... bit6=g
//   rbo       - ripple-blank out; 1 when this digit was blanked as a leading zero
//   invalid   - 1 when BCD is 10-15 and neither lamp_test nor blank is active

module bcd_to_seven_seg #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] BCD,
    input  logic       lamp_test,
    input  logic       blank,
    input  logic       rbi,
    output logic [6:0] SEG,
    output logic       rbo,
    output logic       invalid
);

    // Polarity mask; XOR with an active-high pattern gives the pin-level drive.
    localparam logic [6:0] PolMask = {7{ACTIVE_LOW}};
    localparam logic [6:0] SegOff  = 7'h00 ^ PolMask;

    logic [6:0] digit_pat;
    logic [6:0] seg_hi;
    logic [6:0] seg_d;
    logic       rbo_d;
    logic       invalid_d;

    // Active-high gfedcba patterns; 6 and 9 are drawn with their tails.
    always_comb begin
        digit_pat = 7'h40;
        case (BCD)
            4'd0:    digit_pat = 7'h3F;
            4'd1:    digit_pat = 7'h06;
            4'd2:    digit_pat = 7'h5B;
            4'd3:    digit_pat = 7'h4F;
            4'd4:    digit_pat = 7'h66;
            4'd5:    digit_pat = 7'h6D;
            4'd6:    digit_pat = 7'h7D;
            4'd7:    digit_pat = 7'h07;
            4'd8:    digit_pat = 7'h7F;
            4'd9:    digit_pat = 7'h6F;
            default: digit_pat = 7'h40; // dash for 10-15
        endcase
    end

    // Control priority: lamp test, blank, invalid code, ripple blank, normal digit.
    always_comb begin
        seg_hi    = digit_pat;
        rbo_d     = 1'b0;
        invalid_d = 1'b0;
        if (lamp_test) begin
            seg_hi = 7'h7F;
        end else if (blank) begin
            seg_hi = 7'h00;
        end else if (BCD > 4'd9) begin
            seg_hi    = 7'h40;
            invalid_d = 1'b1;
        end else if (rbi && (BCD == 4'd0)) begin
            seg_hi = 7'h00;
            rbo_d  = 1'b1;
        end
        seg_d = seg_hi ^ PolMask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SEG     <= SegOff;
            rbo     <= 1'b0;
            invalid <= 1'b0;
        end else begin
            SEG     <= seg_d;
            rbo     <= rbo_d;
            invalid <= invalid_d;
        end
    end

endmodule

// File: tb/tb_bcd_to_seven_seg.sv
// Self-checking bench for bcd_to_seven_seg. Two instances share the stimulus: one built
// with ACTIVE_LOW=1 and one with ACTIVE_LOW=0.

module tb_bcd_to_seven_seg;

    logic       clk;
    logic       rst_n;
    logic [3:0] bcd;
    logic       lamp_test;
    logic       blank;
    logic       rbi;
    logic [6:0] seg_al;
    logic       rbo_al;
    logic       inv_al;
    logic [6:0] seg_ah;
    logic       rbo_ah;
    logic       inv_ah;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Active-low digit patterns written out independently of the active-high table.
    localparam logic [6:0] LOW_PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] HIGH_PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    bcd_to_seven_seg #(.ACTIVE_LOW(1'b1)) dut_al (
        .clk       (clk),
        .rst_n     (rst_n),
        .BCD       (bcd),
        .lamp_test (lamp_test),
        .blank     (blank),
        .rbi       (rbi),
        .SEG       (seg_al),
        .rbo       (rbo_al),
        .invalid   (inv_al)
    );

    bcd_to_seven_seg #(.ACTIVE_LOW(1'b0)) dut_ah (
        .clk       (clk),
        .rst_n     (rst_n),
        .BCD       (bcd),
        .lamp_test (lamp_test),
        .blank     (blank),
        .rbi       (rbi),
        .SEG       (seg_ah),
        .rbo       (rbo_ah),
        .invalid   (inv_ah)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    // Reference model: returns {active-high seg, rbo, invalid} from the priority rules.
    function automatic logic [8:0] model(input logic [3:0] b, input logic lt, input logic bl,
                                         input logic ri);
        if (lt)              return {7'h7F, 1'b0, 1'b0};
        if (bl)              return {7'h00, 1'b0, 1'b0};
        if (int'(b) >= 10)   return {7'h40, 1'b0, 1'b1};
        if (ri && b == 4'd0) return {7'h00, 1'b1, 1'b0};
        return {HIGH_PAT[int'(b)], 1'b0, 1'b0};
    endfunction

    // Drive one set of inputs, let one edge sample them, then settle past the edge.
    task automatic step(input logic [3:0] b, input logic lt, input logic bl, input logic ri);
        bcd       = b;
        lamp_test = lt;
        blank     = bl;
        rbi       = ri;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(4'd8, 1'b0, 1'b0, 1'b0);
        step(4'd8, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (seg_al !== 7'h7F || rbo_al !== 1'b0 || inv_al !== 1'b0)
            $display("FAIL reset_al: got seg=%h rbo=%b inv=%b, want seg=7f rbo=0 inv=0",
                     seg_al, rbo_al, inv_al);
        else pass_cnt++;
        total_cnt++;
        if (seg_ah !== 7'h00 || rbo_ah !== 1'b0 || inv_ah !== 1'b0)
            $display("FAIL reset_ah: got seg=%h rbo=%b inv=%b, want seg=00 rbo=0 inv=0",
                     seg_ah, rbo_ah, inv_ah);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (seg_al !== 7'h7F)
            $display("FAIL reset_hold: got seg=%h, want 7f before first edge", seg_al);
        else pass_cnt++;
        step(4'd8, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (seg_al !== 7'h00 || seg_ah !== 7'h7F)
            $display("FAIL reset_release: got seg=%h/%h, want 00/7f", seg_al, seg_ah);
        else pass_cnt++;
    endtask

    task automatic test_digit_sweep;
        for (int i = 0; i < 10; i++) begin
            step(4'(i), 1'b0, 1'b0, 1'b0);
            total_cnt++;
            if (seg_al !== LOW_PAT[i] || seg_ah !== ~LOW_PAT[i] || rbo_al !== 1'b0 ||
                inv_al !== 1'b0)
                $display("FAIL sweep bcd=%0d: got seg=%h/%h rbo=%b inv=%b, want %h/%h 0 0",
                         i, seg_al, seg_ah, rbo_al, inv_al, LOW_PAT[i], ~LOW_PAT[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_invalid;
        for (int i = 10; i < 16; i++) begin
            step(4'(i), 1'b0, 1'b0, 1'b0);
            total_cnt++;
            if (seg_al !== 7'h3F || seg_ah !== 7'h40 || inv_al !== 1'b1 || inv_ah !== 1'b1 ||
                rbo_al !== 1'b0)
                $display("FAIL invalid bcd=%0d: got seg=%h/%h inv=%b/%b rbo=%b, want 3f/40 1/1 0",
                         i, seg_al, seg_ah, inv_al, inv_ah, rbo_al);
            else pass_cnt++;
        end
        step(4'd5, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (seg_al !== 7'h12 || inv_al !== 1'b0)
            $display("FAIL invalid_recover: got seg=%h inv=%b, want 12 0", seg_al, inv_al);
        else pass_cnt++;
    endtask

    task automatic test_priority;
        step(4'd12, 1'b1, 1'b1, 1'b0);
        total_cnt++;
        if (seg_al !== 7'h00 || inv_al !== 1'b0)
            $display("FAIL prio_lamp: got seg=%h inv=%b, want 00 0", seg_al, inv_al);
        else pass_cnt++;
        step(4'd12, 1'b0, 1'b1, 1'b0);
        total_cnt++;
        if (seg_al !== 7'h7F || inv_al !== 1'b0)
            $display("FAIL prio_blank: got seg=%h inv=%b, want 7f 0", seg_al, inv_al);
        else pass_cnt++;
        step(4'd12, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (seg_al !== 7'h3F || inv_al !== 1'b1)
            $display("FAIL prio_invalid: got seg=%h inv=%b, want 3f 1", seg_al, inv_al);
        else pass_cnt++;
        step(4'd0, 1'b0, 1'b1, 1'b1);
        total_cnt++;
        if (seg_al !== 7'h7F || rbo_al !== 1'b0)
            $display("FAIL prio_blank_rbi: got seg=%h rbo=%b, want 7f 0", seg_al, rbo_al);
        else pass_cnt++;
    endtask

    task automatic test_ripple;
        step(4'd0, 1'b0, 1'b0, 1'b1);
        total_cnt++;
        if (seg_al !== 7'h7F || rbo_al !== 1'b1 || seg_ah !== 7'h00 || rbo_ah !== 1'b1)
            $display("FAIL ripple_zero: got seg=%h/%h rbo=%b/%b, want 7f/00 1/1",
                     seg_al, seg_ah, rbo_al, rbo_ah);
        else pass_cnt++;
        step(4'd7, 1'b0, 1'b0, 1'b1);
        total_cnt++;
        if (seg_al !== 7'h78 || rbo_al !== 1'b0)
            $display("FAIL ripple_nonzero: got seg=%h rbo=%b, want 78 0", seg_al, rbo_al);
        else pass_cnt++;
        step(4'd0, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (seg_al !== 7'h40 || rbo_al !== 1'b0)
            $display("FAIL ripple_units: got seg=%h rbo=%b, want 40 0", seg_al, rbo_al);
        else pass_cnt++;
    endtask

    task automatic test_async_reset;
        step(4'd2, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (seg_al !== 7'h24 || seg_ah !== 7'h5B)
            $display("FAIL async_pre: got seg=%h/%h, want 24/5b", seg_al, seg_ah);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (seg_al !== 7'h7F || seg_ah !== 7'h00 || rbo_al !== 1'b0 || inv_al !== 1'b0)
            $display("FAIL async_assert: got seg=%h/%h rbo=%b inv=%b, want 7f/00 0 0",
                     seg_al, seg_ah, rbo_al, inv_al);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'd9, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (seg_al !== 7'h10 || seg_ah !== 7'h6F)
            $display("FAIL async_resume: got seg=%h/%h, want 10/6f", seg_al, seg_ah);
        else pass_cnt++;
    endtask

    task automatic test_random;
        logic [8:0] exp;
        logic [3:0] b;
        logic       lt;
        logic       bl;
        logic       ri;
        for (int n = 0; n < 300; n++) begin
            b  = 4'($urandom_range(0, 15));
            lt = ($urandom_range(0, 7) == 0);
            bl = ($urandom_range(0, 7) == 0);
            ri = 1'($urandom);
            if ($urandom_range(0, 3) == 0) b = 4'd0;
            exp = model(b, lt, bl, ri);
            step(b, lt, bl, ri);
            total_cnt++;
            if (seg_al !== (exp[8:2] ^ 7'h7F) || seg_ah !== exp[8:2] ||
                rbo_al !== exp[1] || rbo_ah !== exp[1] ||
                inv_al !== exp[0] || inv_ah !== exp[0])
                $display("FAIL random n=%0d in=%h/%b%b%b: got seg=%h/%h rbo=%b/%b inv=%b/%b, want seg=%h/%h rbo=%b inv=%b",
                         n, b, lt, bl, ri, seg_al, seg_ah, rbo_al, rbo_ah, inv_al, inv_ah,
                         exp[8:2] ^ 7'h7F, exp[8:2], exp[1], exp[0]);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bcd       = 4'd8;
        lamp_test = 1'b0;
        blank     = 1'b0;
        rbi       = 1'b0;
        test_reset();
        test_digit_sweep();
        test_invalid();
        test_priority();
        test_ripple();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
